// File: rtl/bpu_ras.sv
// bpu_ras: return address stack for the branch prediction unit.
// Fetch pushes call link addresses and pops on predicted returns speculatively.
// The feedback stage repairs {cnt,ptr} from the checkpoint that travelled with
// the resolved branch, then replays that branch's own push or pop.
// Optional build macro: BPU_RAS_REPAIR_BYPASS_EN. When it is defined, the top,
// valid, full and empty outputs show the repaired state in the flush cycle.
// Resolved branch type encoding: 0 call, 1 return, 2 absolute, 3 pc-relative.
module bpu_ras #(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pred_push_i,
    input  logic                   pred_pop_i,
    input  logic [29:0]            pred_push_addr_i,
    output logic [29:0]            pred_top_o,
    output logic                   pred_top_valid_o,
    output logic [PTR_W+CNT_W-1:0] pred_ckpt_o,
    input  logic                   upd_flush_i,
    input  logic [1:0]             upd_br_type_i,
    input  logic [29:0]            upd_pc_i,
    input  logic [PTR_W+CNT_W-1:0] upd_ckpt_i,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam logic [1:0]       BR_CALL   = 2'd0;
    localparam logic [1:0]       BR_RETURN = 2'd1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEPTH);

    logic [29:0]      stack [DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [CNT_W-1:0] cnt_q;

    logic [PTR_W-1:0] ptr_b;
    logic [CNT_W-1:0] cnt_b;
    logic             do_push;
    logic             do_pop;
    logic [29:0]      push_data;

    logic [PTR_W-1:0] ptr_n;
    logic [CNT_W-1:0] cnt_n;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] ptr_inc;
    logic [PTR_W-1:0] ptr_dec;

    logic [29:0]      view_top;
    logic [CNT_W-1:0] view_cnt;

    // Select the starting state and the operation: a flush restores the
    // checkpoint and replays the resolved branch, discarding fetch's request.
    always_comb begin
        cnt_b     = cnt_q;
        ptr_b     = ptr_q;
        do_push   = pred_push_i;
        do_pop    = pred_pop_i;
        push_data = pred_push_addr_i;
        if (upd_flush_i) begin
            cnt_b     = upd_ckpt_i[PTR_W +: CNT_W];
            ptr_b     = upd_ckpt_i[PTR_W-1:0];
            do_push   = (upd_br_type_i == BR_CALL);
            do_pop    = (upd_br_type_i == BR_RETURN);
            push_data = 30'(upd_pc_i + 30'd1);
        end
    end

    // Shared stack arithmetic for both the speculative and repair paths.
    always_comb begin
        ptr_inc = PTR_W'(ptr_b + 1'b1);
        ptr_dec = PTR_W'(ptr_b - 1'b1);
        ptr_n   = ptr_b;
        cnt_n   = cnt_b;
        wr_en   = 1'b0;
        wr_idx  = ptr_b;
        if (do_push && do_pop) begin
            // Call-and-return in one slot: replace the top in place.
            wr_en = 1'b1;
            if (cnt_b == '0) begin
                cnt_n = CNT_W'(1);
            end
        end else if (do_push) begin
            // Wrapping past a full stack silently drops the oldest entry.
            ptr_n  = ptr_inc;
            wr_en  = 1'b1;
            wr_idx = ptr_inc;
            cnt_n  = (cnt_b >= CNT_MAX) ? CNT_MAX : CNT_W'(cnt_b + 1'b1);
        end else if (do_pop && (cnt_b != '0)) begin
            ptr_n = ptr_dec;
            cnt_n = CNT_W'(cnt_b - 1'b1);
        end
    end

    // Stack registers; reset clears every entry so a fresh top reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_n;
            cnt_q <= cnt_n;
            if (wr_en) begin
                stack[wr_idx] <= push_data;
            end
        end
    end

`ifdef BPU_RAS_REPAIR_BYPASS_EN
    // During a flush expose the post-repair top, forwarding the entry being
    // written this cycle since the array still holds the old value.
    always_comb begin
        view_top = stack[ptr_q];
        view_cnt = cnt_q;
        if (upd_flush_i) begin
            view_cnt = cnt_n;
            if (wr_en && (wr_idx == ptr_n)) begin
                view_top = push_data;
            end else begin
                view_top = stack[ptr_n];
            end
        end
    end
`else
    // Outputs come from registered state only; repairs show a cycle later.
    always_comb begin
        view_top = stack[ptr_q];
        view_cnt = cnt_q;
    end
`endif

    // The checkpoint always reflects registered state before this cycle's op.
    always_comb begin
        pred_top_o       = view_top;
        pred_top_valid_o = (view_cnt != '0);
        empty_o          = (view_cnt == '0);
        full_o           = (view_cnt == CNT_MAX);
        pred_ckpt_o      = {cnt_q, ptr_q};
    end

endmodule

// File: tb/tb_bpu_ras.sv
// Directed bench for bpu_ras at DEPTH=4 with hand-computed expectations.
module tb_bpu_ras;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
    localparam int CNT_W = 3;
    localparam logic [1:0] BR_CALL   = 2'd0;
    localparam logic [1:0] BR_RETURN = 2'd1;
    localparam logic [1:0] BR_PCREL  = 2'd3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   pred_push_i;
    logic                   pred_pop_i;
    logic [29:0]            pred_push_addr_i;
    logic [29:0]            pred_top_o;
    logic                   pred_top_valid_o;
    logic [PTR_W+CNT_W-1:0] pred_ckpt_o;
    logic                   upd_flush_i;
    logic [1:0]             upd_br_type_i;
    logic [29:0]            upd_pc_i;
    logic [PTR_W+CNT_W-1:0] upd_ckpt_i;
    logic                   full_o;
    logic                   empty_o;

    int n_chk  = 0;
    int n_pass = 0;

    bpu_ras #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .pred_push_i      (pred_push_i),
        .pred_pop_i       (pred_pop_i),
        .pred_push_addr_i (pred_push_addr_i),
        .pred_top_o       (pred_top_o),
        .pred_top_valid_o (pred_top_valid_o),
        .pred_ckpt_o      (pred_ckpt_o),
        .upd_flush_i      (upd_flush_i),
        .upd_br_type_i    (upd_br_type_i),
        .upd_pc_i         (upd_pc_i),
        .upd_ckpt_i       (upd_ckpt_i),
        .full_o           (full_o),
        .empty_o          (empty_o)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] ck(input int cnt, input int ptr);
        logic [2:0] c;
        logic [1:0] p;
        c = 3'(cnt);
        p = 2'(ptr);
        return {c, p};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic idle();
        pred_push_i      = 1'b0;
        pred_pop_i       = 1'b0;
        pred_push_addr_i = '0;
        upd_flush_i      = 1'b0;
        upd_br_type_i    = BR_PCREL;
        upd_pc_i         = '0;
        upd_ckpt_i       = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic cyc(input logic push, input logic pop, input logic [29:0] addr);
        pred_push_i      = push;
        pred_pop_i       = pop;
        pred_push_addr_i = addr;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic set_flush(input logic [1:0] t, input logic [29:0] pc, input logic [4:0] c,
                             input logic push, input logic [29:0] addr);
        upd_flush_i      = 1'b1;
        upd_br_type_i    = t;
        upd_pc_i         = pc;
        upd_ckpt_i       = c;
        pred_push_i      = push;
        pred_push_addr_i = addr;
    endtask

    logic [29:0] exp_tops [3] = '{30'h4, 30'h3, 30'h2};

    initial begin
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_top",   32'(pred_top_o), 32'h0);
        chk("rst_valid", 32'(pred_top_valid_o), 32'h0);
        chk("rst_ckpt",  32'(pred_ckpt_o), 32'h0);
        chk("rst_empty", 32'(empty_o), 32'h1);
        chk("rst_full",  32'(full_o), 32'h0);

        // simple push / pop
        cyc(1, 0, 30'h100);
        cyc(1, 0, 30'h200);
        chk("pp_top2",  32'(pred_top_o), 32'h200);
        chk("pp_ckpt2", 32'(pred_ckpt_o), 32'(ck(2, 2)));
        cyc(0, 1, 30'h0);
        chk("pp_top1",  32'(pred_top_o), 32'h100);
        chk("pp_ckpt1", 32'(pred_ckpt_o), 32'(ck(1, 1)));
        cyc(0, 1, 30'h0);
        chk("pp_empty", 32'(empty_o), 32'h1);
        chk("pp_valid", 32'(pred_top_valid_o), 32'h0);

        // overflow wrap
        do_reset();
        for (int i = 1; i <= 5; i++) cyc(1, 0, 30'(i));
        chk("ov_full", 32'(full_o), 32'h1);
        chk("ov_top",  32'(pred_top_o), 32'h5);
        chk("ov_ckpt", 32'(pred_ckpt_o), 32'(ck(4, 1)));
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 30'h0);
            chk($sformatf("ov_pop%0d", i + 1), 32'(pred_top_o), 32'(exp_tops[i]));
        end
        cyc(0, 1, 30'h0);
        chk("ov_pop4_empty", 32'(empty_o), 32'h1);
        cyc(0, 1, 30'h0);
        chk("ov_pop5_ckpt", 32'(pred_ckpt_o), 32'(ck(0, 1)));
        chk("ov_pop5_full", 32'(full_o), 32'h0);

        // repair after wrong-path calls
        do_reset();
        cyc(1, 0, 30'h10);
        chk("rp_ckptA", 32'(pred_ckpt_o), 32'(ck(1, 1)));
        cyc(1, 0, 30'h20);
        cyc(1, 0, 30'h30);
        chk("rp_spec_ckpt", 32'(pred_ckpt_o), 32'(ck(3, 3)));
        set_flush(BR_CALL, 30'h40, ck(1, 1), 1'b1, 30'h999);
        step();
        chk("rp_call_top",  32'(pred_top_o), 32'h41);
        chk("rp_call_ckpt", 32'(pred_ckpt_o), 32'(ck(2, 2)));

        // repair with return and with other types; same-cycle push discarded
        set_flush(BR_RETURN, 30'h0, ck(2, 2), 1'b1, 30'h555);
        step();
        chk("rp_ret_ckpt", 32'(pred_ckpt_o), 32'(ck(1, 1)));
        chk("rp_ret_top",  32'(pred_top_o), 32'h10);
        set_flush(BR_PCREL, 30'h0, ck(2, 2), 1'b1, 30'h666);
        step();
        chk("rp_pcr_ckpt", 32'(pred_ckpt_o), 32'(ck(2, 2)));
        chk("rp_pcr_top",  32'(pred_top_o), 32'h41);

        // simultaneous push and pop
        do_reset();
        cyc(1, 0, 30'h100);
        cyc(1, 1, 30'h300);
        chk("pu_top",  32'(pred_top_o), 32'h300);
        chk("pu_ckpt", 32'(pred_ckpt_o), 32'(ck(1, 1)));
        cyc(0, 1, 30'h0);
        cyc(1, 1, 30'h301);
        chk("pu0_ckpt", 32'(pred_ckpt_o), 32'(ck(1, 0)));
        chk("pu0_top",  32'(pred_top_o), 32'h301);

        // call repair visibility: same cycle with bypass, next cycle without
        set_flush(BR_CALL, 30'h7F, ck(1, 0), 1'b0, 30'h0);
        #1;
`ifdef BPU_RAS_REPAIR_BYPASS_EN
        chk("by_same_top", 32'(pred_top_o), 32'h80);
`else
        chk("by_same_top", 32'(pred_top_o), 32'h301);
`endif
        chk("by_same_ckpt", 32'(pred_ckpt_o), 32'(ck(1, 0)));
        step();
        chk("by_next_top",  32'(pred_top_o), 32'h80);
        chk("by_next_ckpt", 32'(pred_ckpt_o), 32'(ck(2, 1)));

        // link address wraps within 30 bits
        set_flush(BR_CALL, 30'h3FFF_FFFF, ck(2, 1), 1'b0, 30'h0);
        step();
        chk("wrap_top",  32'(pred_top_o), 32'h0);
        chk("wrap_ckpt", 32'(pred_ckpt_o), 32'(ck(3, 2)));
        chk("wrap_valid", 32'(pred_top_valid_o), 32'h1);

        // reset overrides a same-cycle push and drops state
        rst = 1'b1;
        pred_push_i = 1'b1;
        pred_push_addr_i = 30'h123;
        step();
        rst = 1'b0;
        chk("mrst_ckpt",  32'(pred_ckpt_o), 32'h0);
        chk("mrst_top",   32'(pred_top_o), 32'h0);
        chk("mrst_empty", 32'(empty_o), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bpu_ras.md
# bpu_ras

Return address stack for the branch prediction unit. At fetch, it supplies the predicted target for `_RETURN`-class branches and records `_CALL` link addresses speculatively. Downstream, the branch feedback stage resolves branches and sends back a flush, the resolved branch type and the checkpoint issued at prediction time. The block uses these to repair its speculative state. It is the stateful consumer of the feedback stage's `br_type`/`flush` outputs, sitting beside the BTB/PHT in the BPU.

## Interface
- `DEPTH`, 8, number of stack entries; power of two, at least 2.
- `PTR_W`, $clog2(DEPTH), pointer width (derived).
- `CNT_W`, $clog2(DEPTH)+1, occupancy width (derived).

Ports:
- `clk` input 1: clock.
- `rst` input 1: reset. Synchronous, active-high. One clock; reset is synchronous and active-high.
- `pred_push_i` input 1: fetch predicts a call this cycle.
- `pred_pop_i` input 1: fetch predicts a return this cycle.
- `pred_push_addr_i` input 30: link word address (`pc[31:2]+1`) to push.
- `pred_top_o` output 30: predicted return target, as a word address.
- `pred_top_valid_o` output 1: stack non-empty, so `pred_top_o` is usable.
- `pred_ckpt_o` output PTR_W+CNT_W: `{cnt,ptr}` before this cycle's push/pop. Travels with the instruction.
- `upd_flush_i` input 1: feedback-stage flush (misprediction or CSR redirect).
- `upd_br_type_i` input 2: resolved type (`_CALL`, `_RETURN`, `_ABSOLUTE`, `_PC_RELATIVE`).
- `upd_pc_i` input 30: resolved instruction `pc[31:2]`.
- `upd_ckpt_i` input PTR_W+CNT_W: checkpoint returned with the resolved instruction.
- `full_o` output 1: `cnt == DEPTH`.
- `empty_o` output 1: `cnt == 0`.

## Operation
**State**
- `stack[DEPTH]`, 30 bits each.
- `ptr`, which indexes the top entry.
- `cnt`, in the range 0..DEPTH.

**Outputs**
- `pred_top_o` = `stack[ptr]`.
- `pred_top_valid_o` = `cnt != 0`.
- `pred_ckpt_o` = `{cnt,ptr}`, taken from registered state.

**Speculative update** (applies only when `upd_flush_i` is 0):
- Push only: `ptr+1` (mod DEPTH), write `stack[ptr+1]`, then `cnt = min(cnt+1, DEPTH)`.
- Pop only: if `cnt != 0`, then `ptr-1` (mod DEPTH) and `cnt-1`; otherwise no change.
- Push and pop together: overwrite `stack[ptr]`. `ptr` and `cnt` are unchanged, except that at `cnt==0` the count becomes 1.

**Repair** (`upd_flush_i` is 1; has priority and discards same-cycle push/pop):
- Restore `{cnt,ptr}` from `upd_ckpt_i`.
- Apply the resolved instruction's own effect:
  - `_CALL`: push `upd_pc_i+1`.
  - `_RETURN`: pop, with the empty rule above.
  - Other types: restore only.
- The arithmetic is identical to speculative update.

**Boundaries**
- Push while full overwrites the oldest entry (wrap) and `cnt` stays at DEPTH.
- A checkpoint whose entries have since been overwritten restores the pointer anyway. Stale contents are accepted as a misprediction source.
- All pointer arithmetic is modulo DEPTH. `upd_pc_i+1` wraps within 30 bits.

## Timing
**Reset** (at the next rising edge with `rst=1`):
- `ptr=0`, `cnt=0`, all entries 0.
- `pred_top_o=0`, `pred_top_valid_o=0`, `pred_ckpt_o=0`, `empty_o=1`, `full_o=0`.
- `rst` overrides flush and push/pop in the same cycle.
- Reset mid-operation drops all state.

**Latency**
- Push/pop in cycle N is visible on `pred_top_o` and `pred_ckpt_o` in cycle N+1.
- Repair in cycle N is visible in N+1, unless the bypass below is enabled.

**Handshakes**
- There is no handshake; the block accepts every cycle.
- The caller must not assert push/pop during a stall cycle it will replay.

**Combinational paths**
- None from inputs to outputs without the bypass.
- `pred_ckpt_o` is always registered-state-based.

## Configuration
- `BPU_RAS_REPAIR_BYPASS_EN` defined:
  - In a cycle with `upd_flush_i=1`, `pred_top_o`, `pred_top_valid_o`, `empty_o` and `full_o` reflect the post-repair state combinationally.
  - Example: on a `_CALL` repair, `pred_top_o` shows `upd_pc_i+1` in the same cycle.
  - This lets the redirected fetch use the repaired top immediately.
- Not defined: outputs are purely registered-state-based, and the repaired view appears one cycle later.
- Register state and its update are identical in both builds.

## Test plan
All scenarios use DEPTH=4.
- **Reset, then simple push/pop.** Push `0x100` then `0x200` in consecutive cycles. The next cycle shows top `0x200`, `cnt=2`. One pop gives top `0x100`. A second pop gives `empty_o=1`, `pred_top_valid_o=0`.
- **Overflow wrap.** Push `0x1`..`0x5`. Result: `full_o=1`, top `0x5`. Four pops return 5,4,3,2. A fifth pop is ignored and `cnt` stays 0.
- **Repair after a wrong-path call.**
  - Push `0x10`, giving ckpt A = `{1,1}`.
  - Push `0x20` and `0x30` speculatively.
  - Flush with `upd_ckpt_i=A`, `_CALL`, `upd_pc_i=0x40`.
  - Next cycle: top `0x41`, `cnt=2`, `ptr=2`.
- **Repair with `_RETURN` and with other types.**
  - Checkpoint `{2,2}` with `_RETURN` gives `cnt=1`, `ptr=1`.
  - Checkpoint `{2,2}` with `_PC_RELATIVE` gives `{2,2}`.
  - A same-cycle push is discarded in both cases.
- **Simultaneous push and pop.**
  - With top `0x100` and `cnt=1`, push `0x300` with pop: top becomes `0x300`, `cnt=1`.
  - At `cnt=0` the same stimulus gives `cnt=1`.
- **Bypass build.** With `BPU_RAS_REPAIR_BYPASS_EN` defined, a `_CALL` repair with `upd_pc_i=0x7F` shows `pred_top_o=0x80` in the flush cycle. Without the macro it appears one cycle later.
